dmactr_mc: RTL
==============

Name: dmactr_mc

Overview:
Multi-channel, parametrised DMA controller for the shared memory/I-O bus; next generation of the single-channel burst engine.
- Up to NCH channels with per-channel programmable transfer length and address mode, selected by round-robin arbitration.
- Owns the bus via the breq_/bgrt_ handshake and moves data as alternating read/write beats: read address driven one cycle, captured data written the next.
- Signals per-channel completion on eop_.

Parameters:
NCH, 4, number of DMA channels (1..8)
ADDR_W, 16, bus address width (`BUS_ADDR_WIDTH)
DATA_W, 16, bus data width (`DATA_WIDTH)
LEN_W, 4, length field width; transfer = dlen+1 beats (max 2^LEN_W)
TMO_W, 8, grant-timeout counter width (optional feature only)

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
addr  out  ADDR_W  bus address
odata  out  DATA_W  write data
idata  in  DATA_W  read data, valid in cycle after read address is driven
rw_  out  1  1=Read, 0=Write
breq_  out  1  bus request, active-low
bgrt_  in  1  bus grant, active-low
dsaddr  in  NCH*ADDR_W  per-channel source address, channel i at [i*ADDR_W +: ADDR_W]
ddaddr  in  NCH*ADDR_W  per-channel destination address
dmode  in  NCH*2  per-channel mode: 00 M2M, 01 M2IO (dst fixed), 10 IO2M (src fixed), 11 IO2IO (both fixed)
dlen  in  NCH*LEN_W  per-channel beats minus one
dreq_  in  NCH  per-channel request, active-low, level
eop_  out  NCH  per-channel end-of-process, active-low one-cycle pulse
err_  out  NCH  per-channel grant-timeout pulse, active-low (present only with DMA_GRANT_TMO_EN)

Behaviour:
- Reset: addr=0, odata=0, rw_=1, breq_=1, eop_=all 1, err_=all 1, state=IDLE, rr pointer=0, beat=0.
- IDLE:
  - Drives addr=0, odata=0, rw_=1; eop_ returns to all 1.
  - If any dreq_ bit is 0: pick the first requesting channel at or after the rr pointer, wrapping modulo NCH.
  - Latch that channel's dsaddr, ddaddr, dmode and dlen; later input changes are ignored until DONE.
  - breq_<=0, beat<=0, go REQ.
- REQ: wait for bgrt_==0. Then addr<=src, rw_<=1, go WRITE. bgrt_ is sampled only in REQ, and the arbiter holds the grant while breq_=0.
- WRITE:
  - addr<=dst_eff, rw_<=0, odata<=idata.
  - If beat==len go DONE; else beat<=beat+1, go READ.
- READ: addr<=src_eff using the updated beat, rw_<=1, go WRITE.
- Effective addresses:
  - src_eff = src+beat unless mode is IO2M or IO2IO, then src.
  - dst_eff = dst+beat unless mode is M2IO or IO2IO, then dst.
  - Sums are ADDR_W bits, wrap modulo 2^ADDR_W.
- DONE: eop_[ch]<=0 for one cycle, breq_<=1, rw_<=1, addr<=0, odata<=0, rr pointer<=ch+1 mod NCH, go IDLE.
- Timing: grant present at REQ gives 2*(len+1)+3 cycles from first IDLE sample to eop_ low.
- Re-requests: a channel must release dreq_ after eop_. If it is still 0 it is re-served, but only after other pending channels (round robin).
- dlen=0 is a single beat. dlen=all-ones gives 2^LEN_W beats.
- Reset mid-transfer aborts immediately to reset values; no eop_ is issued.

Optional Feature:
DMA_GRANT_TMO_EN
- Defined:
  - A TMO_W counter runs in REQ.
  - If bgrt_ stays 1 for 2^TMO_W-1 cycles: err_[ch]<=0 one cycle, breq_<=1, rr pointer advances, go IDLE. No eop_ is issued.
- Undefined: REQ waits indefinitely, err_ is absent, and no counter is synthesised.

Decomposition:
- Shared define.h additions: state codes (IDLE, REQ, READ, WRITE, DONE) and mode codes (M2M, M2IO, IO2M, IO2IO).
- Reuse existing `Enable_/`Disable_/`Read/`Write.
- One sub-module: dma_rr_arb (NCH-bit request vector plus pointer, producing a one-hot/index grant, combinational).

Test Plan:
- ch0 M2M, src 0x0010, dst 0x0040, dlen=3, mem[0x10..0x13]=A0..A3, bgrt_ immediate -> writes A0..A3 to 0x40..0x43, rw_ alternating, eop_[0] low exactly 1 cycle at cycle 11, breq_ high the same cycle.
- ch1 M2IO, src 0x0100, dst 0x8000, dlen=1 -> two writes to 0x8000 with mem[0x100] then mem[0x101]; ch2 IO2M, src 0x8001 -> reads 0x8001 repeatedly, writes consecutive dst.
- dreq_ = 4'b0000 held low -> service order 0,1,2,3,0; each eop_ bit pulses once per transfer.
- src 0xFFFE, dlen=3, M2M -> read addresses FFFE, FFFF, 0000, 0001.
- reset asserted in mid-WRITE of a dlen=7 transfer -> next cycle breq_=1, addr=0, rw_=1, eop_ all 1; a new request restarts at beat 0.
- With DMA_GRANT_TMO_EN and TMO_W=4, bgrt_ held 1 -> err_ pulses after 15 REQ cycles, breq_ returns to 1, next channel is served.

Source files
------------

// File: rtl/dmactr_mc_pkg.sv
// dmactr_mc_pkg: shared definitions for the multi-channel DMA controller.
// Holds the FSM state codes, the per-channel address-mode codes, the
// active-low enable/disable and read/write bus levels, and small helpers
// that decode which side of a transfer stays at a fixed (I/O) address.
package dmactr_mc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        MODE_M2M   = 2'b00,
        MODE_M2IO  = 2'b01,
        MODE_IO2M  = 2'b10,
        MODE_IO2IO = 2'b11
    } mode_e;

    localparam logic ENABLE_N  = 1'b0;
    localparam logic DISABLE_N = 1'b1;
    localparam logic RW_READ   = 1'b1;
    localparam logic RW_WRITE  = 1'b0;

    // Source side is an I/O port that must not increment.
    function automatic logic src_fixed(input logic [1:0] mode);
        return (mode == MODE_IO2M) || (mode == MODE_IO2IO);
    endfunction

    // Destination side is an I/O port that must not increment.
    function automatic logic dst_fixed(input logic [1:0] mode);
        return (mode == MODE_M2IO) || (mode == MODE_IO2IO);
    endfunction

endpackage

// File: rtl/dmactr_mc_rr_arb.sv
// dma_rr_arb: combinational round-robin arbiter.
// Ports:
//   req     in  NCH    active-high request vector
//   ptr     in  IDX_W  channel with highest priority this round
//   gnt_vld out 1      at least one request is pending
//   gnt_idx out IDX_W  first requesting channel at or after ptr (wrapping)
module dma_rr_arb #(
    parameter int NCH   = 4,
    parameter int IDX_W = 2
) (
    input  logic [NCH-1:0]   req,
    input  logic [IDX_W-1:0] ptr,
    output logic             gnt_vld,
    output logic [IDX_W-1:0] gnt_idx
);

    // Scan offsets from farthest to nearest so the nearest request wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            int j;
            j = int'(ptr) + k;
            if (j >= NCH) begin
                j = j - NCH;
            end else begin
                j = j;
            end
            if (req[j]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDX_W'(j);
            end else begin
                gnt_vld = gnt_vld;
            end
        end
    end

endmodule

// File: rtl/dmactr_mc.sv
// dmactr_mc: multi-channel DMA controller with round-robin channel selection.
// Optional feature macro: DMA_GRANT_TMO_EN (grant timeout, err_ port, TMO_W).
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   addr, odata, rw_  bus address, write data, 1=read / 0=write
//   idata             read data, returned in the cycle the read address is on the bus
//   breq_, bgrt_      active-low bus request / grant
//   dsaddr, ddaddr    per-channel source / destination addresses (packed)
//   dmode, dlen       per-channel address mode and beat count minus one
//   dreq_, eop_       per-channel request level / end-of-process pulse
//   err_              per-channel grant-timeout pulse (DMA_GRANT_TMO_EN only)
module dmactr_mc
    import dmactr_mc_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 4
`ifdef DMA_GRANT_TMO_EN
    , parameter int TMO_W = 8
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_W-1:0]     addr,
    output logic [DATA_W-1:0]     odata,
    input  logic [DATA_W-1:0]     idata,
    output logic                  rw_,
    output logic                  breq_,
    input  logic                  bgrt_,
    input  logic [NCH*ADDR_W-1:0] dsaddr,
    input  logic [NCH*ADDR_W-1:0] ddaddr,
    input  logic [NCH*2-1:0]      dmode,
    input  logic [NCH*LEN_W-1:0]  dlen,
    input  logic [NCH-1:0]        dreq_,
    output logic [NCH-1:0]        eop_
`ifdef DMA_GRANT_TMO_EN
    , output logic [NCH-1:0]      err_
`endif
);

    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    ch_q, ch_d;
    logic [ADDR_W-1:0]   src_q, src_d, dst_q, dst_d;
    logic [1:0]          mode_q, mode_d;
    logic [LEN_W-1:0]    len_q, len_d, beat_q, beat_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   odata_q, odata_d;
    logic                rw_q, rw_d, breq_q, breq_d;
    logic [NCH-1:0]      eop_q, eop_d;

    logic [ADDR_W-1:0]   src_arr  [NCH];
    logic [ADDR_W-1:0]   dst_arr  [NCH];
    logic [1:0]          mode_arr [NCH];
    logic [LEN_W-1:0]    len_arr  [NCH];
    logic                gnt_vld;
    logic [IDX_W-1:0]    gnt_idx;
    logic [ADDR_W-1:0]   src_eff, dst_eff;
    logic [IDX_W-1:0]    ptr_next;

`ifdef DMA_GRANT_TMO_EN
    // Last count before the (2^TMO_W-1)-th ungranted REQ cycle.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [NCH-1:0]      err_q, err_d;
`endif

    // Unpack the per-channel configuration buses.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            src_arr[i]  = dsaddr[i*ADDR_W +: ADDR_W];
            dst_arr[i]  = ddaddr[i*ADDR_W +: ADDR_W];
            mode_arr[i] = dmode[i*2 +: 2];
            len_arr[i]  = dlen[i*LEN_W +: LEN_W];
        end
    end

    dma_rr_arb #(.NCH(NCH), .IDX_W(IDX_W)) u_arb (
        .req     (~dreq_),
        .ptr     (ptr_q),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    // Beat-offset addresses; fixed I/O sides ignore the beat count.
    always_comb begin
        if (src_fixed(mode_q)) begin
            src_eff = src_q;
        end else begin
            src_eff = src_q + ADDR_W'(beat_q);
        end
        if (dst_fixed(mode_q)) begin
            dst_eff = dst_q;
        end else begin
            dst_eff = dst_q + ADDR_W'(beat_q);
        end
        if (ch_q == IDX_W'(NCH - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = ch_q + IDX_W'(1);
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ch_d    = ch_q;
        src_d   = src_q;
        dst_d   = dst_q;
        mode_d  = mode_q;
        len_d   = len_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        odata_d = odata_q;
        rw_d    = rw_q;
        breq_d  = breq_q;
        eop_d   = '1;
`ifdef DMA_GRANT_TMO_EN
        tmo_d   = tmo_q;
        err_d   = '1;
`endif
        case (state_q)
            ST_IDLE: begin
                addr_d  = '0;
                odata_d = '0;
                rw_d    = RW_READ;
                breq_d  = DISABLE_N;
                if (gnt_vld) begin
                    // Configuration is frozen here for the whole transfer.
                    ch_d    = gnt_idx;
                    src_d   = src_arr[gnt_idx];
                    dst_d   = dst_arr[gnt_idx];
                    mode_d  = mode_arr[gnt_idx];
                    len_d   = len_arr[gnt_idx];
                    beat_d  = '0;
                    breq_d  = ENABLE_N;
                    state_d = ST_REQ;
`ifdef DMA_GRANT_TMO_EN
                    tmo_d   = '0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bgrt_ == ENABLE_N) begin
                    addr_d  = src_q;
                    rw_d    = RW_READ;
                    state_d = ST_WRITE;
                end else begin
`ifdef DMA_GRANT_TMO_EN
                    tmo_d = tmo_q + TMO_W'(1);
                    if (tmo_q == TMO_LAST) begin
                        err_d[ch_q] = 1'b0;
                        breq_d      = DISABLE_N;
                        ptr_d       = ptr_next;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_REQ;
                    end
`else
                    state_d = ST_REQ;
`endif
                end
            end
            ST_WRITE: begin
                // idata belongs to the read address driven last cycle.
                addr_d  = dst_eff;
                rw_d    = RW_WRITE;
                odata_d = idata;
                if (beat_q == len_q) begin
                    state_d = ST_DONE;
                end else begin
                    beat_d  = beat_q + LEN_W'(1);
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                addr_d  = src_eff;
                rw_d    = RW_READ;
                state_d = ST_WRITE;
            end
            ST_DONE: begin
                eop_d[ch_q] = 1'b0;
                breq_d      = DISABLE_N;
                rw_d        = RW_READ;
                addr_d      = '0;
                odata_d     = '0;
                ptr_d       = ptr_next;
                state_d     = ST_IDLE;
            end
            default: begin
                breq_d  = DISABLE_N;
                rw_d    = RW_READ;
                addr_d  = '0;
                odata_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            ch_q    <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            mode_q  <= 2'b00;
            len_q   <= '0;
            beat_q  <= '0;
            addr_q  <= '0;
            odata_q <= '0;
            rw_q    <= RW_READ;
            breq_q  <= DISABLE_N;
            eop_q   <= '1;
`ifdef DMA_GRANT_TMO_EN
            tmo_q   <= '0;
            err_q   <= '1;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ch_q    <= ch_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            odata_q <= odata_d;
            rw_q    <= rw_d;
            breq_q  <= breq_d;
            eop_q   <= eop_d;
`ifdef DMA_GRANT_TMO_EN
            tmo_q   <= tmo_d;
            err_q   <= err_d;
`endif
        end
    end

    assign addr  = addr_q;
    assign odata = odata_q;
    assign rw_   = rw_q;
    assign breq_ = breq_q;
    assign eop_  = eop_q;
`ifdef DMA_GRANT_TMO_EN
    assign err_  = err_q;
`endif

endmodule
